// File: rtl/game_pkg.sv
// Shared game definitions: state encodings, winner codes, bust limit and the
// hand-comparison rule used by the turn controller and the handed-flag blocks.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_DEAL    = 3'b001,
    ST_P1_TURN = 3'b010,
    ST_P1_DONE = 3'b011,
    ST_P2_DONE = 3'b100,
    ST_P2_TURN = 3'b101,
    ST_RESULT  = 3'b110,
    ST_UNUSED  = 3'b111
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_TIE  = 2'b11
  } winner_e;

  localparam int unsigned BUST_LIMIT = 21;

  function automatic logic is_bust(input logic [4:0] score);
    return score > 5'(BUST_LIMIT);
  endfunction

  // Both bust counts as a tie, as does an equal non-bust score.
  function automatic winner_e judge(input logic [4:0] s1, input logic [4:0] s2);
    logic b1;
    logic b2;
    b1 = is_bust(s1);
    b2 = is_bust(s2);
    if (b1 && b2)    return WIN_TIE;
    else if (b1)     return WIN_P2;
    else if (b2)     return WIN_P1;
    else if (s1 > s2) return WIN_P1;
    else if (s2 > s1) return WIN_P2;
    else             return WIN_TIE;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Idle-turn watchdog: counts consecutive action-free cycles within a turn and
// flags expiry on the cycle that completes TIMEOUT_CYC idle cycles.
module turn_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_o
);

  localparam int unsigned W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign expire_o = tick_i && (count_q >= LAST);

  always_comb begin
    count_d = count_q;
    if (clear_i || expire_o) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/turn_controller.sv
// Two-player card-game turn sequencer: deals on request, tracks cards per player,
// judges the round. Optional idle-turn timeout enabled by macro TURN_TIMEOUT_EN.
module turn_controller
  import game_pkg::*;
#(
  parameter int unsigned MAX_CARDS   = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_hit,
  input  logic       p1_stand,
  input  logic       p2_hit,
  input  logic       p2_stand,
  input  logic [4:0] p1_score,
  input  logic [4:0] p2_score,
  output logic [2:0] state,
  output logic       deal_req,
  output logic       deal_player,
  output logic [2:0] p1_cards,
  output logic [2:0] p2_cards,
  output logic [1:0] winner,
  output logic       result_valid
);

  localparam logic [2:0] MAX_C = 3'(MAX_CARDS);

  game_state_e state_q, state_d;
  logic [2:0]  p1_cards_q, p1_cards_d;
  logic [2:0]  p2_cards_q, p2_cards_d;
  winner_e     winner_q, winner_d;
  logic        valid_q, valid_d;

  logic take1;
  logic take2;
  logic turn_timeout;

  assign take1 = p1_hit && !p1_stand && (p1_cards_q < MAX_C);
  assign take2 = p2_hit && !p2_stand && (p2_cards_q < MAX_C);

`ifdef TURN_TIMEOUT_EN
  logic turn_tick;
  logic turn_clear;

  // Outside a turn the counter is held clear, so each turn starts from zero.
  always_comb begin
    turn_tick  = 1'b0;
    turn_clear = 1'b1;
    if (state_q == ST_P1_TURN) begin
      turn_tick  = !p1_hit && !p1_stand;
      turn_clear = take1;
    end else if (state_q == ST_P2_TURN) begin
      turn_tick  = !p2_hit && !p2_stand;
      turn_clear = take2;
    end
  end

  turn_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_turn_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (turn_clear),
    .tick_i  (turn_tick),
    .expire_o(turn_timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign turn_timeout       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    p1_cards_d  = p1_cards_q;
    p2_cards_d  = p2_cards_q;
    winner_d    = winner_q;
    valid_d     = valid_q;
    deal_req    = 1'b0;
    deal_player = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DEAL;
          p1_cards_d = '0;
          p2_cards_d = '0;
          winner_d   = WIN_NONE;
          valid_d    = 1'b0;
        end
      end

      ST_DEAL: begin
        p1_cards_d = '0;
        p2_cards_d = '0;
        winner_d   = WIN_NONE;
        valid_d    = 1'b0;
        state_d    = ST_P1_TURN;
      end

      ST_P1_TURN: begin
        deal_req = take1;
        if (take1) begin
          p1_cards_d = p1_cards_q + 3'd1;
        end
        if (p1_stand || is_bust(p1_score) || turn_timeout ||
            (take1 && (p1_cards_q + 3'd1 == MAX_C))) begin
          state_d = ST_P1_DONE;
        end
      end

      ST_P1_DONE: state_d = ST_P2_TURN;

      ST_P2_TURN: begin
        deal_req    = take2;
        deal_player = 1'b1;
        if (take2) begin
          p2_cards_d = p2_cards_q + 3'd1;
        end
        if (p2_stand || is_bust(p2_score) || turn_timeout ||
            (take2 && (p2_cards_q + 3'd1 == MAX_C))) begin
          state_d = ST_P2_DONE;
        end
      end

      ST_P2_DONE: begin
        winner_d = judge(p1_score, p2_score);
        valid_d  = 1'b1;
        state_d  = ST_RESULT;
      end

      ST_RESULT: begin
        if (start) begin
          state_d    = ST_DEAL;
          p1_cards_d = '0;
          p2_cards_d = '0;
          winner_d   = WIN_NONE;
          valid_d    = 1'b0;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        p1_cards_d = '0;
        p2_cards_d = '0;
        winner_d   = WIN_NONE;
        valid_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      p1_cards_q <= '0;
      p2_cards_q <= '0;
      winner_q   <= WIN_NONE;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_cards_q <= p1_cards_d;
      p2_cards_q <= p2_cards_d;
      winner_q   <= winner_d;
      valid_q    <= valid_d;
    end
  end

  assign state        = state_q;
  assign p1_cards     = p1_cards_q;
  assign p2_cards     = p2_cards_q;
  assign winner       = winner_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller: directed scenarios followed by random
// play, all compared against a behavioural round model held in the bench.
module tb_turn_controller;

  localparam int MAXC = 5;
  localparam int TOC  = 4;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, p1_hit, p1_stand, p2_hit, p2_stand;
  logic [4:0] p1_score, p2_score;
  logic [2:0] state;
  logic       deal_req, deal_player;
  logic [2:0] p1_cards, p2_cards;
  logic [1:0] winner;
  logic       result_valid;

  int checks   = 0;
  int failures = 0;

  // Model: phase numbers use the published state codes.
  int m_phase, m_c1, m_c2, m_win, m_rv, m_idle;

  always #5 clk = ~clk;

  turn_controller #(
    .MAX_CARDS  (MAXC),
    .TIMEOUT_CYC(TOC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .p1_hit      (p1_hit),
    .p1_stand    (p1_stand),
    .p2_hit      (p2_hit),
    .p2_stand    (p2_stand),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
    .state       (state),
    .deal_req    (deal_req),
    .deal_player (deal_player),
    .p1_cards    (p1_cards),
    .p2_cards    (p2_cards),
    .winner      (winner),
    .result_valid(result_valid)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_winner(input int s1, input int s2);
    if (s1 > 21 && s2 > 21) return 3;
    if (s1 > 21) return 2;
    if (s2 > 21) return 1;
    if (s1 == s2) return 3;
    return (s1 > s2) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_c1 = 0; m_c2 = 0; m_win = 0; m_rv = 0; m_idle = 0;
  endtask

  // Evaluate a player's turn: returns whether a card is taken and whether the turn ends.
  task automatic turn_eval(input bit h, input bit s, input int sc, input int cards,
                           output bit take, output bit leave, output bit idle);
    bit expired;
    take    = h && !s && cards < MAXC;
    idle    = !h && !s;
    expired = TO_EN && idle && (m_idle + 1 >= TOC);
    leave   = s || sc > 21 || expired || (take && cards + 1 == MAXC);
  endtask

  task automatic tick(input bit rst, input bit st, input bit h1, input bit s1,
                      input bit h2, input bit s2, input int sc1, input int sc2);
    bit take, leave, idle, exp_dr;
    reset = rst; start = st;
    p1_hit = h1; p1_stand = s1; p2_hit = h2; p2_stand = s2;
    p1_score = 5'(sc1); p2_score = 5'(sc2);
    #2;
    take = 0; leave = 0; idle = 0;
    if (m_phase == 2) turn_eval(h1, s1, sc1, m_c1, take, leave, idle);
    if (m_phase == 5) turn_eval(h2, s2, sc2, m_c2, take, leave, idle);
    exp_dr = take;
    chk("state", int'(state), m_phase);
    chk("p1_cards", int'(p1_cards), m_c1);
    chk("p2_cards", int'(p2_cards), m_c2);
    chk("winner", int'(winner), m_win);
    chk("result_valid", int'(result_valid), m_rv);
    chk("deal_req", int'(deal_req), int'(exp_dr));
    if (exp_dr) chk("deal_player", int'(deal_player), (m_phase == 5) ? 1 : 0);

    if (rst) begin
      model_reset();
    end else begin
      case (m_phase)
        0, 6: if (st) begin m_phase = 1; m_c1 = 0; m_c2 = 0; m_win = 0; m_rv = 0; end
        1: begin m_phase = 2; m_c1 = 0; m_c2 = 0; m_win = 0; m_rv = 0; m_idle = 0; end
        2: begin
          if (take) m_c1++;
          m_idle = (idle && !leave) ? m_idle + 1 : 0;
          if (leave) m_phase = 3;
        end
        3: begin m_phase = 5; m_idle = 0; end
        5: begin
          if (take) m_c2++;
          m_idle = (idle && !leave) ? m_idle + 1 : 0;
          if (leave) m_phase = 4;
        end
        4: begin m_win = ref_winner(sc1, sc2); m_rv = 1; m_phase = 6; end
        default: model_reset();
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    p1_hit = 1'b0; p1_stand = 1'b0; p2_hit = 1'b0; p2_stand = 1'b0;
    p1_score = '0; p2_score = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset values, then start: 000 -> 001 -> 010
    tick(1, 0, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    chk("enter_p1_turn", int'(state), 2);

    // P1 hits twice then stands, P2 stands, 18 vs 17
    tick(0, 0, 1, 0, 0, 0, 18, 17);
    tick(0, 0, 1, 0, 1, 0, 18, 17);
    tick(0, 0, 0, 1, 0, 0, 18, 17);
    tick(0, 0, 0, 0, 0, 0, 18, 17);
    tick(0, 0, 0, 0, 0, 1, 18, 17);
    tick(0, 0, 0, 0, 0, 0, 18, 17);
    chk("r1_state", int'(state), 6);
    chk("r1_winner", int'(winner), 1);
    chk("r1_p1_cards", int'(p1_cards), 2);
    tick(0, 0, 0, 0, 0, 0, 5, 5);

    // P1 busts on a hit, P2 on 20
    tick(0, 1, 0, 0, 0, 0, 10, 20);
    tick(0, 0, 0, 0, 0, 0, 10, 20);
    tick(0, 0, 1, 0, 0, 0, 22, 20);
    chk("bust_exit", int'(state), 3);
    tick(0, 0, 0, 0, 0, 0, 22, 20);
    tick(0, 0, 0, 0, 0, 1, 22, 20);
    tick(0, 0, 0, 0, 0, 0, 22, 20);
    chk("r2_winner", int'(winner), 2);

    // Five hits saturate the hand; a further hit is ignored
    tick(0, 1, 0, 0, 0, 0, 3, 3);
    tick(0, 0, 0, 0, 0, 0, 3, 3);
    for (int i = 0; i < MAXC; i++) tick(0, 0, 1, 0, 0, 0, 3 + i, 3);
    chk("max_cards", int'(p1_cards), MAXC);
    chk("max_exit", int'(state), 3);
    tick(0, 0, 1, 0, 0, 0, 9, 3);
    tick(0, 0, 0, 0, 0, 1, 9, 3);
    tick(0, 0, 0, 0, 0, 0, 9, 3);
    chk("r3_winner", int'(winner), 1);

    // Hit+stand is a stand; reset mid P2 turn
    tick(0, 1, 0, 0, 0, 0, 4, 4);
    tick(0, 0, 0, 0, 0, 0, 4, 4);
    tick(0, 0, 1, 1, 0, 0, 4, 4);
    tick(0, 0, 0, 0, 0, 0, 4, 4);
    tick(0, 0, 0, 0, 1, 0, 4, 4);
    tick(1, 1, 0, 0, 1, 0, 4, 4);
    chk("reset_mid_p2", int'(state), 0);

    // Idle turn: timeout forces P1_DONE only when the timer is built in
    tick(0, 1, 0, 0, 0, 0, 4, 4);
    tick(0, 0, 0, 0, 0, 0, 4, 4);
    for (int i = 0; i < TOC; i++) tick(0, 0, 0, 0, 0, 0, 4, 4);
    chk("idle_turn", int'(state), TO_EN ? 3 : 2);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0, 1, 0, 4, 4);
    tick(1, 0, 0, 0, 0, 0, 0, 0);

    // Random play
    for (int n = 0; n < 600; n++) begin
      tick(($urandom % 60) == 0, ($urandom % 6) == 0,
           ($urandom % 3) == 0, ($urandom % 5) == 0,
           ($urandom % 3) == 0, ($urandom % 5) == 0,
           int'($urandom_range(0, 24)), int'($urandom_range(0, 24)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
